add16_seq: RTL and testbench

Two-pass 16-bit address sequencer in front of the shared 8-bit three-input carry-chain adder. It computes `base + offs`, with `offs` treated as an unsigned index or a signed 8-bit branch displacement. The low byte and, only when needed, the high byte go through the single adder in consecutive cycles. It also arbitrates the adder against the microcoded ALU, which always has priority, and reports page crossings for cycle-penalty accounting.

---
 rtl/add_pkg.sv | 21 ++
 rtl/add16_seq_if.sv | 34 +++
 rtl/add16_seq.sv | 110 +++++++++++
 tb/tb_add16_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the 16-bit address sequencer and its 8-bit carry-chain adder.
package add_pkg;

    // Op-select codes index the adder's LUT INIT; renumbering them means regenerating that INIT.
    localparam logic [2:0] OP_ADD01  = 3'b000;
    localparam logic [2:0] OP_ADD012 = 3'b001;
    localparam logic [2:0] OP_SUB01  = 3'b010;
    localparam logic [2:0] OP_AND01  = 3'b011;
    localparam logic [2:0] OP_OR01   = 3'b100;
    localparam logic [2:0] OP_XOR01  = 3'b101;

    localparam logic MODE_IDX = 1'b0;
    localparam logic MODE_REL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

endpackage

// File: rtl/add16_seq_if.sv
// Request, result and shared-adder signals of the address sequencer.
// Handshake: start is taken on a rising edge where start=1 and ready=1; done pulses for one
// cycle with result/page_cross valid, and those stay put until the next accepted start.
interface add16_seq_if;
    logic        start;
    logic        mode;
    logic [15:0] base;
    logic [7:0]  offs;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        page_cross;
    logic        alu_req;
    logic        alu_gnt;
    logic [7:0]  add_i0;
    logic [7:0]  add_i1;
    logic [7:0]  add_i2;
    logic [2:0]  add_op;
    logic        add_ci;
    logic [7:0]  add_o;
    logic        add_co;

    modport master (
        output start, mode, base, offs, alu_req, add_o, add_co,
        input  ready, done, result, page_cross, alu_gnt,
        input  add_i0, add_i1, add_i2, add_op, add_ci
    );

    modport slave (
        input  start, mode, base, offs, alu_req, add_o, add_co,
        output ready, done, result, page_cross, alu_gnt,
        output add_i0, add_i1, add_i2, add_op, add_ci
    );
endinterface

// File: rtl/add16_seq.sv
// Two-pass base+offset address sequencer sharing one 8-bit adder with the microcoded ALU.
// The ALU always wins the adder; the sequencer simply holds its state while alu_req is high.
module add16_seq
    import add_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    add16_seq_if.slave bus,
    output state_t     o_state
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_base;
    logic [7:0]  r_offs;
    logic        r_mode;
    logic [7:0]  r_lo;
    logic        r_c;
    logic [15:0] r_result;
    logic        r_page_cross;
    logic        r_done;
    logic        w_sext;
    logic        w_adj;

    // A negative displacement adds 0xFF to the high byte, so its low-byte carry cancels the borrow.
    assign w_sext = (r_mode == MODE_REL) && r_offs[7];
    assign w_adj  = bus.add_co ^ w_sext;

    assign bus.ready      = (r_state == IDLE);
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.page_cross = r_page_cross;
    assign bus.alu_gnt    = bus.alu_req;
    assign o_state        = r_state;

    always_comb begin
        w_state_nxt = r_state;
        bus.add_i0  = '0;
        bus.add_i1  = '0;
        bus.add_i2  = '0;
        bus.add_op  = '0;
        bus.add_ci  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = LO;
            end
            LO: begin
                bus.add_i0 = r_base[7:0];
                bus.add_i1 = r_offs;
                bus.add_op = OP_ADD01;
                if (!bus.alu_req) w_state_nxt = w_adj ? HI : IDLE;
            end
            HI: begin
                bus.add_i0 = r_base[15:8];
                bus.add_i1 = w_sext ? 8'hFF : 8'h00;
                bus.add_op = OP_ADD01;
                bus.add_ci = r_c;
                if (!bus.alu_req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_offs       <= '0;
            r_mode       <= MODE_IDX;
            r_lo         <= '0;
            r_c          <= 1'b0;
            r_result     <= '0;
            r_page_cross <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_base <= bus.base;
                        r_offs <= bus.offs;
                        r_mode <= bus.mode;
                    end
                end
                LO: begin
                    if (!bus.alu_req) begin
                        r_lo <= bus.add_o;
                        r_c  <= bus.add_co;
                        if (!w_adj) begin
                            r_result     <= {r_base[15:8], bus.add_o};
                            r_page_cross <= 1'b0;
                            r_done       <= 1'b1;
                        end
                    end
                end
                HI: begin
                    // High-byte carry out is dropped: addresses wrap modulo 2^16.
                    if (!bus.alu_req) begin
                        r_result     <= {bus.add_o, r_lo};
                        r_page_cross <= 1'b1;
                        r_done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_seq.sv
// Bench for add16_seq: behavioural adder/ALU mux around the DUT, randomized operations
// against a plain-arithmetic reference, plus directed cases with literal results.
module tb_add16_seq;
    import add_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    add16_seq_if bus ();
    state_t      dbg_state;

    add16_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- adder + ALU operand mux ----------------
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ci;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_x;
    logic       add_c;
    logic [2:0] add_sel;
    logic [8:0] add_s;

    assign add_a   = bus.alu_gnt ? alu_a    : bus.add_i0;
    assign add_b   = bus.alu_gnt ? alu_b    : bus.add_i1;
    assign add_x   = bus.alu_gnt ? 8'h00    : bus.add_i2;
    assign add_c   = bus.alu_gnt ? alu_ci   : bus.add_ci;
    assign add_sel = bus.alu_gnt ? OP_ADD01 : bus.add_op;
    assign add_s   = (add_sel == OP_ADD01)  ? ({1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c}) :
                     (add_sel == OP_ADD012) ? ({1'b0, add_a} + {1'b0, add_b} + {1'b0, add_x} + {8'd0, add_c}) :
                                              {1'b0, add_a ^ add_b};
    assign bus.add_o  = add_s[7:0];
    assign bus.add_co = add_s[8];

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    int          due_q[$];
    int          st_q[$];
    int          total;
    int          bad;

    initial begin
        total = 0;
        bad   = 0;
    end

    function automatic logic [16:0] ref_add(input logic m, input logic [15:0] b, input logic [7:0] o);
        logic [15:0] d;
        logic [15:0] r;
        d = m ? {{8{o[7]}}, o} : {8'h00, o};
        r = b + d;
        return {(r[15:8] != b[15:8]), r};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_alu();
        alu_a  = 8'($urandom);
        alu_b  = 8'($urandom);
        alu_ci = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start   = 1'b0;
            bus.alu_req = 1'($urandom_range(0, 1));
            bus.base    = 16'($urandom);
            bus.offs    = 8'($urandom);
            rand_alu();
            @(negedge clk);
        end
        bus.alu_req = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the expected done cycle.
    task automatic do_op(input logic m, input logic [15:0] b, input logic [7:0] o,
                         input int sl, input int sh, input bit poke, output int lat);
        logic [16:0] e;
        int          t0;
        int          due;
        e   = ref_add(m, b, o);
        t0  = cyc;
        due = t0 + 2 + sl + (e[16] ? 1 + sh : 0);
        exp_q.push_back(e);
        due_q.push_back(due);
        st_q.push_back(t0);
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.base    = b;
        bus.offs    = o;
        bus.alu_req = 1'($urandom_range(0, 1));
        rand_alu();
        for (int c = t0 + 1; c < due; c++) begin
            @(negedge clk);
            bus.start   = poke && (c == t0 + 1);
            bus.mode    = 1'($urandom_range(0, 1));
            bus.base    = 16'($urandom);
            bus.offs    = 8'($urandom);
            bus.alu_req = (c <= t0 + sl) || (e[16] && (c >= t0 + sl + 2) && (c <= t0 + sl + 1 + sh));
            rand_alu();
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.alu_req = 1'b0;
        lat = due - t0;
    endtask

    // ---------------- compare process ----------------
    logic [16:0] cmp_e;
    int          cmp_d;
    int          cmp_st;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("alu_gnt", {31'd0, bus.alu_gnt}, {31'd0, bus.alu_req});
            if (rst_n) begin
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done: got done=1 want done=0 (cycle %0d)", cyc);
                    end else begin
                        cmp_e = exp_q.pop_front();
                        cmp_d = due_q.pop_front();
                        cmp_st = st_q.pop_front();
                        check("result", {16'd0, bus.result}, {16'd0, cmp_e[15:0]});
                        check("page_cross", {31'd0, bus.page_cross}, {31'd0, cmp_e[16]});
                        check("done_cycle", cyc - cmp_st, cmp_d - cmp_st);
                        check("ready_on_done", {31'd0, bus.ready}, 32'd1);
                    end
                end else if (due_q.size() > 0 && cyc > due_q[0]) begin
                    total++;
                    bad++;
                    $display("FAIL done_timeout: got no done want done at cycle %0d", due_q[0]);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    void'(st_q.pop_front());
                end
                check("ready", {31'd0, bus.ready},
                      {31'd0, (st_q.size() == 0) || (cyc == st_q[0])});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    int          lat;
    logic        r_m;
    logic [15:0] r_b;
    logic [7:0]  r_o;
    int          r_sl;
    int          r_sh;
    bit          r_poke;
    logic [16:0] rst_e;
    int          rst_t0;
    logic [7:0]  edge_bytes[4];

    initial begin
        edge_bytes[0] = 8'h00;
        edge_bytes[1] = 8'h7F;
        edge_bytes[2] = 8'h80;
        edge_bytes[3] = 8'hFF;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.base    = '0;
        bus.offs    = '0;
        bus.alu_req = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ci      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'h0000);
        check("rst_page_cross", {31'd0, bus.page_cross}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        rst_n = 1'b1;
        idle(2);

        do_op(1'b0, 16'h12F0, 8'h05, 0, 0, 1'b0, lat);
        check("idx_nocross_lat", lat, 2);
        check("idx_nocross_done", {31'd0, bus.done}, 32'd1);
        check("idx_nocross_res", {16'd0, bus.result}, 32'h12F5);
        check("idx_nocross_pc", {31'd0, bus.page_cross}, 32'd0);

        do_op(1'b0, 16'h12F0, 8'h20, 0, 0, 1'b0, lat);
        check("idx_cross_lat", lat, 3);
        check("idx_cross_done", {31'd0, bus.done}, 32'd1);
        check("idx_cross_res", {16'd0, bus.result}, 32'h1310);
        check("idx_cross_pc", {31'd0, bus.page_cross}, 32'd1);

        do_op(1'b1, 16'h1205, 8'hF0, 0, 0, 1'b1, lat);
        check("rel_neg_cross_lat", lat, 3);
        check("rel_neg_cross_res", {16'd0, bus.result}, 32'h11F5);
        check("rel_neg_cross_pc", {31'd0, bus.page_cross}, 32'd1);

        do_op(1'b1, 16'h0000, 8'hFF, 0, 0, 1'b0, lat);
        check("rel_wrap_res", {16'd0, bus.result}, 32'hFFFF);
        check("rel_wrap_pc", {31'd0, bus.page_cross}, 32'd1);

        do_op(1'b1, 16'h1280, 8'hF0, 0, 0, 1'b0, lat);
        check("rel_neg_same_lat", lat, 2);
        check("rel_neg_same_res", {16'd0, bus.result}, 32'h1270);
        check("rel_neg_same_pc", {31'd0, bus.page_cross}, 32'd0);

        do_op(1'b0, 16'h12F0, 8'h20, 3, 2, 1'b0, lat);
        check("stall_lat", lat, 8);
        check("stall_done", {31'd0, bus.done}, 32'd1);
        check("stall_res", {16'd0, bus.result}, 32'h1310);

        // Abort an operation in HI with a synchronous reset.
        rst_e  = ref_add(1'b0, 16'h12F0, 8'h20);
        rst_t0 = cyc;
        exp_q.push_back(rst_e);
        due_q.push_back(rst_t0 + 3);
        st_q.push_back(rst_t0);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.base  = 16'h12F0;
        bus.offs  = 8'h20;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        due_q.delete();
        st_q.delete();
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'h0000);
        check("abort_pc", {31'd0, bus.page_cross}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        for (int n = 0; n < 150; n++) begin
            r_m  = 1'($urandom_range(0, 1));
            r_b  = 16'($urandom);
            r_o  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r_b[7:0] = edge_bytes[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) r_o = edge_bytes[$urandom_range(0, 3)];
            r_sl   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            r_sh   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            r_poke = ($urandom_range(0, 3) == 0);
            do_op(r_m, r_b, r_o, r_sl, r_sh, r_poke, lat);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(4);
        check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
